mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning the word address width into the shared 1024-word memory.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the memory word width.
REQ-003 The block SHALL have parameter STARVE_MAX, default 4, meaning the maximum consecutive data grants while a fetch waits.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset: clock  in  1  sole clock, all state on posedge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 i_req  in  1  fetch request, held until i_gnt; i_addr  in  ADDR_W  fetch address.
REQ-007 i_flush  in  1  branch taken; cancel in-flight fetch.
REQ-008 i_gnt  out  1  fetch granted this cycle; i_rvalid  out  1  fetch data valid; i_rdata  out  DATA_W  fetch data.
REQ-009 d_req  in  1  data request, held until d_gnt; d_we  in  1  1 = store, 0 = load.
REQ-010 d_addr  in  ADDR_W  data address; d_wdata  in  DATA_W  store data.
REQ-011 d_gnt  out  1  data granted this cycle; d_rvalid  out  1  load data valid; d_rdata  out  DATA_W  load data.
REQ-012 mem_en  out  1, mem_we  out  1, mem_addr  out  ADDR_W, mem_wdata  out  DATA_W: single-port synchronous memory command.
REQ-013 mem_rdata  in  DATA_W  memory read data, valid one cycle after a read command.

Function
REQ-014 At most one of i_gnt, d_gnt SHALL be high in any cycle; grants are combinational from requests and registered state.
REQ-015 In a grant cycle mem_en SHALL be 1, mem_addr/mem_we/mem_wdata driven from the granted requester; otherwise mem_en = mem_we = 0.
REQ-016 Arbiter states: IDLE (no grant), GNT_I, GNT_D; state register records the owner of the previous cycle for response routing.
REQ-017 When only one requester is active it SHALL be granted the same cycle; back-to-back grants every cycle SHALL be allowed.
REQ-018 When both request, data SHALL win (older instruction), except as in REQ-026.
REQ-019 A granted load SHALL assert d_rvalid exactly one cycle later with d_rdata = mem_rdata; a granted fetch likewise asserts i_rvalid/i_rdata.
REQ-020 A granted store SHALL produce no d_rvalid; d_gnt is its completion.
REQ-021 i_flush high SHALL force i_gnt = 0 that cycle and suppress i_rvalid for a fetch granted the previous cycle; data traffic is unaffected.
REQ-022 i_rvalid and d_rvalid SHALL never be high in the same cycle.
REQ-023 i_rdata/d_rdata SHALL hold their last valid value while the matching rvalid is low.

Reset
REQ-024 While reset is high: all grants, rvalids, mem_en, mem_we = 0; rdata outputs = 0; state = IDLE; starve counter = 0.
REQ-025 Reset asserted mid-access SHALL drop the pending response; first grant possible on the first clock edge after deassertion.

Configuration
REQ-026 With MEM_ARB_STARVE_GUARD_EN defined: a counter increments (saturating at STARVE_MAX) on each d_gnt while i_req is high and clears on i_gnt or when i_req is low; when it equals STARVE_MAX and both request, fetch SHALL win.
REQ-027 Without MEM_ARB_STARVE_GUARD_EN: strict data priority, no counter logic; STARVE_MAX unused.

Structure
REQ-028 Package mips_mem_pkg SHALL hold the owner enum (OWN_NONE, OWN_I, OWN_D) and default ADDR_W/DATA_W constants.
REQ-029 The starvation counter SHALL be sub-module mem_arb_starve_ctr, instantiated only under MEM_ARB_STARVE_GUARD_EN.

Verification
REQ-030 Fetch alone, i_addr=5, Mem[5]=0x2800000A -> i_gnt same cycle, next cycle i_rvalid=1, i_rdata=0x2800000A.
REQ-031 Both request, d_we=0 d_addr=120, i_addr=6 -> cycle0 d_gnt, cycle1 i_gnt + d_rvalid, cycle2 i_rvalid.
REQ-032 Store d_addr=200 d_wdata=0x55 -> mem_we=1, mem_addr=200, no d_rvalid; later load 200 returns 0x55.
REQ-033 Fetch granted cycle0, i_flush=1 cycle1 -> i_rvalid stays 0 in cycle1; i_gnt=0 in cycle1.
REQ-034 Guard enabled, STARVE_MAX=4, d_req and i_req held continuously -> pattern 4 d_gnt, 1 i_gnt, repeating; guard disabled -> d_gnt every cycle.
REQ-035 Reset asserted in cycle after load grant -> d_rvalid never asserts; all outputs 0 during reset.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and default widths for the instruction/data memory arbiter.
package mips_mem_pkg;

  localparam int DEF_ADDR_W     = 10;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_STARVE_MAX = 4;

  // Owner of the memory port in the previous cycle, used to route responses.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

endpackage : mips_mem_pkg

// File: rtl/mem_arb_starve_ctr.sv
// Counts consecutive data grants while a fetch waits; starved_o asks the
// arbiter to let the fetch through ahead of data.
module mem_arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic i_req_i,
  input  logic i_gnt_i,
  input  logic d_gnt_i,
  output logic starved_o
);

  localparam int                CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_gnt_i || !i_req_i) begin
      cnt_d = '0;
    end else if (d_gnt_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starved_o = (cnt_q == CNT_MAX);

endmodule : mem_arb_starve_ctr

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port synchronous memory between instruction fetch and
// data access. Define MEM_ARB_STARVE_GUARD_EN to bound fetch starvation.
module mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clock,
  input  logic              reset,
  // instruction side
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  // data side
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // memory port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  owner_e            state_q, state_d;
  logic              d_load_q, d_load_d;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
  logic              i_want, d_want, starved;

  // Grants are gated by reset so nothing reaches memory while it is held.
  assign i_want = i_req && !i_flush && !reset;
  assign d_want = d_req && !reset;

`ifdef MEM_ARB_STARVE_GUARD_EN
  mem_arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clock     (clock),
    .reset     (reset),
    .i_req_i   (i_req),
    .i_gnt_i   (i_gnt),
    .d_gnt_i   (d_gnt),
    .starved_o (starved)
  );
`else
  // Guard disabled: a fetch is never forced ahead of data.
  assign starved = (STARVE_MAX < 0);
`endif

  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = OWN_NONE;
    d_load_d  = 1'b0;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = i_addr;
    mem_wdata = d_wdata;
    if (d_want && !(i_want && starved)) begin
      d_gnt    = 1'b1;
      mem_en   = 1'b1;
      mem_we   = d_we;
      mem_addr = d_addr;
      state_d  = OWN_D;
      d_load_d = !d_we;
    end else if (i_want) begin
      i_gnt   = 1'b1;
      mem_en  = 1'b1;
      state_d = OWN_I;
    end
  end

  // A flush in the response cycle cancels the fetch that was granted before it.
  assign i_rvalid = (state_q == OWN_I) && !i_flush;
  assign d_rvalid = (state_q == OWN_D) && d_load_q;

  assign i_rdata = i_rvalid ? mem_rdata : i_rdata_q;
  assign d_rdata = d_rvalid ? mem_rdata : d_rdata_q;

  // NOTE: registers use non-blocking assignments so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= OWN_NONE;
      d_load_q  <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q  <= state_d;
      d_load_q <= d_load_d;
      if (i_rvalid) i_rdata_q <= mem_rdata;
      if (d_rvalid) d_rdata_q <= mem_rdata;
    end
  end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int DEPTH      = 1 << ADDR_W;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              i_req = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic              i_flush = 1'b0;
  logic              i_gnt, i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic              d_gnt, d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 clock = ~clock;

  mem_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_flush   (i_flush),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Power-on memory image shared by the bench memory and the model.
  function automatic logic [DATA_W-1:0] init_word(input int a);
    if (a == 5) return 32'h2800_000A;
    return (32'(a) * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  // Single-port synchronous memory: read data appears one cycle after the command.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  written;
  logic              mem_clr = 1'b1;

  always @(posedge clock) begin
    if (mem_clr) begin
      written <= '0;
    end else if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr]     <= mem_wdata;
        written[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= written[mem_addr] ? mem[mem_addr] : init_word(int'(mem_addr));
      end
    end
  end

  // Reference model: pending responses, last delivered data, shadow memory.
  logic [DATA_W-1:0] ref_mem [DEPTH];
  bit                m_pend_i, m_pend_d;
  logic [DATA_W-1:0] m_pend_i_data, m_pend_d_data, m_last_i, m_last_d;
  int                m_cnt;
  bit                last_ig, last_dg;

  task automatic m_reset();
    m_pend_i = 1'b0;
    m_pend_d = 1'b0;
    m_last_i = '0;
    m_last_d = '0;
    m_cnt    = 0;
    last_ig  = 1'b0;
    last_dg  = 1'b0;
  endtask

  task automatic idle_inputs();
    i_req = 1'b0; i_flush = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
  endtask

  // One bus cycle: drive at the falling edge, compare outputs, advance the model.
  task automatic step(input logic ir, input logic [ADDR_W-1:0] ia, input logic fl,
                      input logic dr, input logic dw, input logic [ADDR_W-1:0] da,
                      input logic [DATA_W-1:0] wd);
    bit                e_ig, e_dg, e_iv, e_dv, fetch_ok, force_i;
    logic [DATA_W-1:0] e_ird, e_drd;
    logic [ADDR_W-1:0] e_addr;
    @(negedge clock);
    i_req = ir; i_addr = ia; i_flush = fl;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = wd;
    #1;
    cyc++;
    fetch_ok = ir && !fl;
    force_i  = GUARD_EN && (m_cnt == STARVE_MAX);
    e_dg     = dr && !(fetch_ok && force_i);
    e_ig     = fetch_ok && !e_dg;
    e_iv     = m_pend_i && !fl;
    e_dv     = m_pend_d;
    e_ird    = e_iv ? m_pend_i_data : m_last_i;
    e_drd    = e_dv ? m_pend_d_data : m_last_d;
    e_addr   = e_dg ? da : ia;

    n_checks++;
    if (i_gnt !== e_ig) $display("FAIL c%0d i_gnt: got %b want %b", cyc, i_gnt, e_ig);
    else n_pass++;
    n_checks++;
    if (d_gnt !== e_dg) $display("FAIL c%0d d_gnt: got %b want %b", cyc, d_gnt, e_dg);
    else n_pass++;
    n_checks++;
    if (mem_en !== (e_ig || e_dg)) $display("FAIL c%0d mem_en: got %b want %b", cyc, mem_en, e_ig || e_dg);
    else n_pass++;
    n_checks++;
    if (mem_we !== (e_dg && dw)) $display("FAIL c%0d mem_we: got %b want %b", cyc, mem_we, e_dg && dw);
    else n_pass++;
    if (e_ig || e_dg) begin
      n_checks++;
      if (mem_addr !== e_addr) $display("FAIL c%0d mem_addr: got %0d want %0d", cyc, mem_addr, e_addr);
      else n_pass++;
    end
    if (e_dg && dw) begin
      n_checks++;
      if (mem_wdata !== wd) $display("FAIL c%0d mem_wdata: got %h want %h", cyc, mem_wdata, wd);
      else n_pass++;
    end
    n_checks++;
    if (i_rvalid !== e_iv) $display("FAIL c%0d i_rvalid: got %b want %b", cyc, i_rvalid, e_iv);
    else n_pass++;
    n_checks++;
    if (d_rvalid !== e_dv) $display("FAIL c%0d d_rvalid: got %b want %b", cyc, d_rvalid, e_dv);
    else n_pass++;
    n_checks++;
    if (i_rdata !== e_ird) $display("FAIL c%0d i_rdata: got %h want %h", cyc, i_rdata, e_ird);
    else n_pass++;
    n_checks++;
    if (d_rdata !== e_drd) $display("FAIL c%0d d_rdata: got %h want %h", cyc, d_rdata, e_drd);
    else n_pass++;

    m_last_i      = e_ird;
    m_last_d      = e_drd;
    m_pend_i      = e_ig;
    m_pend_i_data = ref_mem[ia];
    m_pend_d      = e_dg && !dw;
    m_pend_d_data = ref_mem[da];
    if (e_dg && dw) ref_mem[da] = wd;
    if (e_ig || !ir) m_cnt = 0;
    else if (e_dg && (m_cnt < STARVE_MAX)) m_cnt++;
    last_ig = e_ig;
    last_dg = e_dg;
  endtask

  task automatic step_idle();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b1; i_addr = 10'd3; d_addr = 10'd4;
    repeat (2) @(negedge clock);
    #1;
    n_checks++;
    if ({i_gnt, d_gnt, mem_en, mem_we, i_rvalid, d_rvalid} !== 6'b0)
      $display("FAIL reset_ctrl: got %b want 000000", {i_gnt, d_gnt, mem_en, mem_we, i_rvalid, d_rvalid});
    else n_pass++;
    n_checks++;
    if ({i_rdata, d_rdata} !== '0) $display("FAIL reset_rdata: got %h/%h want 0/0", i_rdata, d_rdata);
    else n_pass++;
    idle_inputs();
    @(posedge clock);
    #1;
    mem_clr = 1'b0;
    reset   = 1'b0;
    m_reset();
  endtask

  task automatic test_fetch_alone();
    step(1'b1, 10'd5, 1'b0, 1'b0, 1'b0, '0, '0);
    n_checks++;
    if (i_gnt !== 1'b1) $display("FAIL fetch_gnt: got %b want 1", i_gnt);
    else n_pass++;
    step_idle();
    n_checks++;
    if (i_rvalid !== 1'b1 || i_rdata !== 32'h2800_000A)
      $display("FAIL fetch_data: got %b/%h want 1/2800000a", i_rvalid, i_rdata);
    else n_pass++;
  endtask

  task automatic test_both_request();
    step(1'b1, 10'd6, 1'b0, 1'b1, 1'b0, 10'd120, '0);
    n_checks++;
    if (d_gnt !== 1'b1 || i_gnt !== 1'b0) $display("FAIL both_c0: got d%b i%b want d1 i0", d_gnt, i_gnt);
    else n_pass++;
    step(1'b1, 10'd6, 1'b0, 1'b0, 1'b0, '0, '0);
    n_checks++;
    if (i_gnt !== 1'b1 || d_rvalid !== 1'b1 || d_rdata !== init_word(120))
      $display("FAIL both_c1: got i_gnt%b d_rvalid%b %h want 1 1 %h", i_gnt, d_rvalid, d_rdata, init_word(120));
    else n_pass++;
    step_idle();
    n_checks++;
    if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0 || i_rdata !== init_word(6))
      $display("FAIL both_c2: got i_rvalid%b d_rvalid%b %h want 1 0 %h", i_rvalid, d_rvalid, i_rdata, init_word(6));
    else n_pass++;
  endtask

  task automatic test_store_load();
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 10'd200, 32'h55);
    n_checks++;
    if (d_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'd200)
      $display("FAIL store_cmd: got gnt%b we%b addr%0d want 1 1 200", d_gnt, mem_we, mem_addr);
    else n_pass++;
    step_idle();
    n_checks++;
    if (d_rvalid !== 1'b0) $display("FAIL store_no_rvalid: got %b want 0", d_rvalid);
    else n_pass++;
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 10'd200, '0);
    step_idle();
    n_checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'h55) $display("FAIL load_back: got %b/%h want 1/55", d_rvalid, d_rdata);
    else n_pass++;
    step_idle();
    n_checks++;
    if (d_rvalid !== 1'b0 || d_rdata !== 32'h55) $display("FAIL rdata_hold: got %b/%h want 0/55", d_rvalid, d_rdata);
    else n_pass++;
  endtask

  task automatic test_flush();
    step(1'b1, 10'd7, 1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b1, 10'd8, 1'b1, 1'b1, 1'b0, 10'd9, '0);
    n_checks++;
    if (i_gnt !== 1'b0 || i_rvalid !== 1'b0 || d_gnt !== 1'b1)
      $display("FAIL flush_c1: got i_gnt%b i_rvalid%b d_gnt%b want 0 0 1", i_gnt, i_rvalid, d_gnt);
    else n_pass++;
    step(1'b1, 10'd8, 1'b0, 1'b0, 1'b0, '0, '0);
    n_checks++;
    if (i_gnt !== 1'b1 || i_rvalid !== 1'b0 || d_rvalid !== 1'b1)
      $display("FAIL flush_c2: got i_gnt%b i_rvalid%b d_rvalid%b want 1 0 1", i_gnt, i_rvalid, d_rvalid);
    else n_pass++;
    step_idle();
    n_checks++;
    if (i_rvalid !== 1'b1 || i_rdata !== init_word(8))
      $display("FAIL flush_c3: got %b/%h want 1/%h", i_rvalid, i_rdata, init_word(8));
    else n_pass++;
  endtask

  task automatic test_starve();
    bit exp_i;
    step_idle();
    for (int k = 0; k < 15; k++) begin
      step(1'b1, 10'(40 + k), 1'b0, 1'b1, 1'b0, 10'(300 + k), '0);
      exp_i = GUARD_EN && ((k % (STARVE_MAX + 1)) == STARVE_MAX);
      n_checks++;
      if (i_gnt !== exp_i || d_gnt !== !exp_i)
        $display("FAIL starve_k%0d: got i%b d%b want i%b d%b", k, i_gnt, d_gnt, exp_i, !exp_i);
      else n_pass++;
    end
    step_idle();
  endtask

  task automatic test_random();
    logic              ir, fl, dr, dw;
    logic [ADDR_W-1:0] ia, da;
    logic [DATA_W-1:0] wd;
    ir = 1'b0; dr = 1'b0; dw = 1'b0; ia = '0; da = '0; wd = '0;
    for (int n = 0; n < 400; n++) begin
      if (!ir || last_ig) begin
        ir = ($urandom_range(0, 3) != 0);
        ia = ADDR_W'($urandom_range(0, DEPTH - 1));
      end
      if (!dr || last_dg) begin
        dr = ($urandom_range(0, 2) != 0);
        dw = $urandom_range(0, 1) != 0;
        da = ADDR_W'($urandom_range(0, 15));
        wd = $urandom;
      end
      fl = ($urandom_range(0, 7) == 0);
      step(ir, ia, fl, dr, dw, da, wd);
    end
    step_idle();
  endtask

  task automatic test_reset_mid();
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 10'd33, '0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b1; i_addr = 10'd5; d_addr = 10'd6;
    #1;
    n_checks++;
    if ({i_gnt, d_gnt, mem_en, mem_we, i_rvalid, d_rvalid} !== 6'b0)
      $display("FAIL midreset_ctrl: got %b want 000000", {i_gnt, d_gnt, mem_en, mem_we, i_rvalid, d_rvalid});
    else n_pass++;
    n_checks++;
    if ({i_rdata, d_rdata} !== '0) $display("FAIL midreset_rdata: got %h/%h want 0/0", i_rdata, d_rdata);
    else n_pass++;
    @(negedge clock);
    #1;
    n_checks++;
    if ({mem_en, d_gnt, d_rvalid} !== 3'b0) $display("FAIL midreset_hold: got %b want 000", {mem_en, d_gnt, d_rvalid});
    else n_pass++;
    idle_inputs();
    @(posedge clock);
    #1;
    reset = 1'b0;
    m_reset();
    step(1'b1, 10'd5, 1'b0, 1'b0, 1'b0, '0, '0);
    n_checks++;
    if (i_gnt !== 1'b1 || d_rvalid !== 1'b0)
      $display("FAIL post_reset: got i_gnt%b d_rvalid%b want 1 0", i_gnt, d_rvalid);
    else n_pass++;
    step_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = init_word(k);
    m_reset();
    test_reset();
    test_fetch_alone();
    test_both_request();
    test_store_load();
    test_flush();
    test_starve();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mem_arbiter
